// File: rtl/ascii_to_scancode_pkg.sv
// Shared PS/2 Set-2 scancode constants, transmit FSM states and sequencing helpers
// for the ASCII-to-scancode encoder (also consumed by the decode path).
package ascii_to_scancode_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_LANG   = 8'h0E;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LANG_MK,
    ST_LANG_F0,
    ST_LANG_BRK,
    ST_SHIFT_MK,
    ST_KEY_MK,
    ST_KEY_F0,
    ST_KEY_BRK,
    ST_SHIFT_F0,
    ST_SHIFT_BRK,
    ST_UNMAPPED,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       push_down;
    logic       push_up;
  } emit_t;

  // Next byte-emitting state after cur, skipping language and shift wrappers when unused.
  function automatic state_e seq_next(input state_e cur, input logic lang_mis,
                                      input logic shift);
    case (cur)
      ST_IDLE:      return lang_mis ? ST_LANG_MK : (shift ? ST_SHIFT_MK : ST_KEY_MK);
      ST_LANG_MK:   return ST_LANG_F0;
      ST_LANG_F0:   return ST_LANG_BRK;
      ST_LANG_BRK:  return shift ? ST_SHIFT_MK : ST_KEY_MK;
      ST_SHIFT_MK:  return ST_KEY_MK;
      ST_KEY_MK:    return ST_KEY_F0;
      ST_KEY_F0:    return ST_KEY_BRK;
      ST_KEY_BRK:   return shift ? ST_SHIFT_F0 : ST_IDLE;
      ST_SHIFT_F0:  return ST_SHIFT_BRK;
      default:      return ST_IDLE;
    endcase
  endfunction

  function automatic emit_t state_byte(input state_e st, input logic [7:0] key);
    emit_t e;
    e = '0;
    case (st)
      ST_LANG_MK:   e = '{code: SC_LANG,   push_down: 1'b1, push_up: 1'b0};
      ST_LANG_BRK:  e = '{code: SC_LANG,   push_down: 1'b0, push_up: 1'b1};
      ST_SHIFT_MK:  e = '{code: SC_LSHIFT, push_down: 1'b1, push_up: 1'b0};
      ST_SHIFT_BRK: e = '{code: SC_LSHIFT, push_down: 1'b0, push_up: 1'b1};
      ST_KEY_MK:    e = '{code: key,       push_down: 1'b1, push_up: 1'b0};
      ST_KEY_BRK:   e = '{code: key,       push_down: 1'b0, push_up: 1'b1};
      ST_LANG_F0, ST_KEY_F0, ST_SHIFT_F0:
                    e = '{code: SC_BREAK,  push_down: 1'b0, push_up: 1'b0};
      default:      e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/ascii_scancode_lut.sv
// Combinational US-layout ASCII to PS/2 Set-2 key lookup returning {mapped, shift, code}.
module ascii_scancode_lut
  import ascii_to_scancode_pkg::*;
(
  input  logic [7:0] ascii,
  output logic       mapped,
  output logic       shift,
  output logic [7:0] code
);

  logic       is_upper;
  logic [7:0] sel;

  // Upper-case letters reuse the lower-case table entry with shift set.
  assign is_upper = (ascii >= 8'h41) && (ascii <= 8'h5A);
  assign sel      = is_upper ? (ascii | 8'h20) : ascii;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    mapped = 1'b1;
    shift  = is_upper;
    code   = 8'h00;
    case (sel)
      "a": code = 8'h1C;  "b": code = 8'h32;  "c": code = 8'h21;  "d": code = 8'h23;
      "e": code = 8'h24;  "f": code = 8'h2B;  "g": code = 8'h34;  "h": code = 8'h33;
      "i": code = 8'h43;  "j": code = 8'h3B;  "k": code = 8'h42;  "l": code = 8'h4B;
      "m": code = 8'h3A;  "n": code = 8'h31;  "o": code = 8'h44;  "p": code = 8'h4D;
      "q": code = 8'h15;  "r": code = 8'h2D;  "s": code = 8'h1B;  "t": code = 8'h2C;
      "u": code = 8'h3C;  "v": code = 8'h2A;  "w": code = 8'h1D;  "x": code = 8'h22;
      "y": code = 8'h35;  "z": code = 8'h1A;
      "1": code = 8'h16;  "2": code = 8'h1E;  "3": code = 8'h26;  "4": code = 8'h25;
      "5": code = 8'h2E;  "6": code = 8'h36;  "7": code = 8'h3D;  "8": code = 8'h3E;
      "9": code = 8'h46;  "0": code = 8'h45;
      "!": begin code = 8'h16; shift = 1'b1; end
      "@": begin code = 8'h1E; shift = 1'b1; end
      "#": begin code = 8'h26; shift = 1'b1; end
      "$": begin code = 8'h25; shift = 1'b1; end
      "%": begin code = 8'h2E; shift = 1'b1; end
      "^": begin code = 8'h36; shift = 1'b1; end
      "&": begin code = 8'h3D; shift = 1'b1; end
      "*": begin code = 8'h3E; shift = 1'b1; end
      "(": begin code = 8'h46; shift = 1'b1; end
      ")": begin code = 8'h45; shift = 1'b1; end
      8'h60: code = 8'h0E;
      "~": begin code = 8'h0E; shift = 1'b1; end
      "-": code = 8'h4E;
      "_": begin code = 8'h4E; shift = 1'b1; end
      "=": code = 8'h55;
      "+": begin code = 8'h55; shift = 1'b1; end
      "[": code = 8'h54;
      "{": begin code = 8'h54; shift = 1'b1; end
      "]": code = 8'h5B;
      "}": begin code = 8'h5B; shift = 1'b1; end
      "\\": code = 8'h5D;
      "|": begin code = 8'h5D; shift = 1'b1; end
      ";": code = 8'h4C;
      ":": begin code = 8'h4C; shift = 1'b1; end
      "'": code = 8'h52;
      "\"": begin code = 8'h52; shift = 1'b1; end
      ",": code = 8'h41;
      "<": begin code = 8'h41; shift = 1'b1; end
      ".": code = 8'h49;
      ">": begin code = 8'h49; shift = 1'b1; end
      "/": code = 8'h4A;
      "?": begin code = 8'h4A; shift = 1'b1; end
      " ":         code = 8'h29;
      8'h09:       code = 8'h0D;
      8'h0A, 8'h0D: code = SC_ENTER;
      8'h08:       code = SC_BKSP;
      default: begin
        mapped = 1'b0;
        shift  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ascii_to_scancode.sv
// Types one ASCII character per handshake as a PS/2 Set-2 make/break sequence.
// Define ASCII_TO_SCANCODE_GAP_EN to force GAP_CYCLES idle cycles after every byte.
module ascii_to_scancode
  import ascii_to_scancode_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_ascii,
  input  logic       in_lang,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_code,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_push_down,
  output logic       out_push_up,
  output logic       lang_state,
  output logic       busy,
  output logic       err_unmapped
);

  logic       lut_mapped;
  logic       lut_shift;
  logic [7:0] lut_code;

  state_e     state;
  state_e     load_state;
  emit_t      load_byte;
  logic [7:0] key_code;
  logic       key_shift;
  logic       lang_mis;

`ifdef ASCII_TO_SCANCODE_GAP_EN
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GAP_W-1:0] gap_cnt;
  state_e           pending;
`endif

  ascii_scancode_lut u_lut (
    .ascii  (in_ascii),
    .mapped (lut_mapped),
    .shift  (lut_shift),
    .code   (lut_code)
  );

  // In IDLE the sequence is planned from the live LUT output so the first byte is ready at N+1.
  always_comb begin
    load_state = ST_IDLE;
    case (state)
      ST_IDLE: load_state = seq_next(ST_IDLE, in_lang != lang_state, lut_shift);
`ifdef ASCII_TO_SCANCODE_GAP_EN
      ST_GAP:  load_state = pending;
`endif
      default: load_state = seq_next(state, lang_mis, key_shift);
    endcase
    load_byte = state_byte(load_state, (state == ST_IDLE) ? lut_code : key_code);
  end

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      out_valid     <= 1'b0;
      out_code      <= 8'h00;
      out_push_down <= 1'b0;
      out_push_up   <= 1'b0;
      lang_state    <= 1'b0;
      err_unmapped  <= 1'b0;
      key_code      <= 8'h00;
      key_shift     <= 1'b0;
      lang_mis      <= 1'b0;
`ifdef ASCII_TO_SCANCODE_GAP_EN
      gap_cnt       <= '0;
      pending       <= ST_IDLE;
`endif
    end else begin
      err_unmapped <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            key_code  <= lut_code;
            key_shift <= lut_shift;
            lang_mis  <= (in_lang != lang_state);
            if (lut_mapped) begin
              state     <= load_state;
              out_valid <= 1'b1;
              {out_code, out_push_down, out_push_up} <= load_byte;
            end else begin
              state        <= ST_UNMAPPED;
              err_unmapped <= 1'b1;
            end
          end
        end

        ST_UNMAPPED: state <= ST_IDLE;

`ifdef ASCII_TO_SCANCODE_GAP_EN
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state     <= pending;
            out_valid <= (pending != ST_IDLE);
            {out_code, out_push_down, out_push_up} <= load_byte;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
`endif

        default: begin
          if (out_valid && out_ready) begin
            if (state == ST_LANG_BRK) lang_state <= ~lang_state;
`ifdef ASCII_TO_SCANCODE_GAP_EN
            state     <= ST_GAP;
            pending   <= load_state;
            gap_cnt   <= GAP_W'(GAP_CYCLES - 1);
            out_valid <= 1'b0;
            {out_code, out_push_down, out_push_up} <= '0;
`else
            state     <= load_state;
            out_valid <= (load_state != ST_IDLE);
            {out_code, out_push_down, out_push_up} <= load_byte;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_to_scancode.sv
// Directed bench for ascii_to_scancode: sequences, language toggle, unmapped, stalls, reset abort.
module tb_ascii_to_scancode;

  localparam int TB_GAP = 4;
`ifdef ASCII_TO_SCANCODE_GAP_EN
  localparam int STEP = TB_GAP + 1;
`else
  localparam int STEP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_ascii = 8'h00;
  logic       in_lang = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_code;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_push_down;
  logic       out_push_up;
  logic       lang_state;
  logic       busy;
  logic       err_unmapped;

  int checks = 0;
  int errors = 0;

  logic [7:0] g_code [32];
  logic       g_pd   [32];
  logic       g_pu   [32];
  logic       g_lang [32];
  int         g_cyc  [32];
  int         n_got;
  int         ready_cyc;

  ascii_to_scancode #(.GAP_CYCLES(TB_GAP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_ascii      (in_ascii),
    .in_lang       (in_lang),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_code      (out_code),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_push_down (out_push_down),
    .out_push_up   (out_push_up),
    .lang_state    (lang_state),
    .busy          (busy),
    .err_unmapped  (err_unmapped)
  );

  always #5 clk = ~clk;

  // Present one character for exactly one accepting edge.
  task automatic send_char(input logic [7:0] ch, input logic lang);
    int w;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL send_ready_timeout: in_ready=%b required 1", in_ready);
    end
    in_ascii = ch;
    in_lang  = lang;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Record every handshaked byte until in_ready returns; checks hold-while-stalled on the way.
  task automatic collect(input bit stall);
    bit         prev_stall;
    bit         done;
    logic [7:0] pc;
    logic       ppd, ppu;
    prev_stall = 1'b0;
    done       = 1'b0;
    pc = 8'h00; ppd = 1'b0; ppu = 1'b0;
    n_got      = 0;
    ready_cyc  = -1;
    for (int k = 1; k <= 600 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ready_cyc = k;
        done      = 1'b1;
      end else begin
        if (prev_stall) begin
          checks++;
          if (out_valid !== 1'b1 || out_code !== pc || out_push_down !== ppd || out_push_up !== ppu) begin
            errors++;
            $display("FAIL stall_hold: got v=%b %h pd=%b pu=%b required v=1 %h pd=%b pu=%b",
                     out_valid, out_code, out_push_down, out_push_up, pc, ppd, ppu);
          end
        end
        out_ready = stall ? ($urandom_range(0, 1) != 0) : 1'b1;
        if (out_valid && out_ready && n_got < 32) begin
          g_code[n_got] = out_code;
          g_pd[n_got]   = out_push_down;
          g_pu[n_got]   = out_push_up;
          g_lang[n_got] = lang_state;
          g_cyc[n_got]  = k;
          n_got++;
        end
        prev_stall = out_valid && !out_ready;
        pc = out_code; ppd = out_push_down; ppu = out_push_up;
      end
    end
    out_ready = 1'b1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL collect_timeout: in_ready never returned, bytes seen %0d", n_got);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_code, out_push_down, out_push_up, lang_state, busy, err_unmapped} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b code=%h pd=%b pu=%b lang=%b busy=%b err=%b required all 0",
               out_valid, out_code, out_push_down, out_push_up, lang_state, busy, err_unmapped);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b busy=%b required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_lower_a();
    logic [9:0] exp [3];
    exp = '{{2'b10, 8'h1C}, {2'b00, 8'hF0}, {2'b01, 8'h1C}};
    send_char("a", 1'b0);
    collect(1'b0);
    checks++;
    if (n_got !== 3) begin
      errors++;
      $display("FAIL lower_a_count: got %0d bytes required 3", n_got);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({g_pd[i], g_pu[i], g_code[i]} !== exp[i]) begin
        errors++;
        $display("FAIL lower_a_byte%0d: got %h required %h", i, {g_pd[i], g_pu[i], g_code[i]}, exp[i]);
      end
    end
    checks++;
    if (g_cyc[0] !== 1 || g_cyc[1] !== 1 + STEP || g_cyc[2] !== 1 + 2 * STEP) begin
      errors++;
      $display("FAIL lower_a_timing: got cycles %0d %0d %0d required 1 %0d %0d",
               g_cyc[0], g_cyc[1], g_cyc[2], 1 + STEP, 1 + 2 * STEP);
    end
    checks++;
    if (ready_cyc !== 1 + 3 * STEP) begin
      errors++;
      $display("FAIL lower_a_ready: got cycle %0d required %0d", ready_cyc, 1 + 3 * STEP);
    end
  endtask

  task automatic test_upper_a(input bit stall, input logic lang);
    logic [9:0] exp [6];
    exp = '{{2'b10, 8'h12}, {2'b10, 8'h1C}, {2'b00, 8'hF0},
            {2'b01, 8'h1C}, {2'b00, 8'hF0}, {2'b01, 8'h12}};
    send_char("A", lang);
    collect(stall);
    checks++;
    if (n_got !== 6) begin
      errors++;
      $display("FAIL upper_a_count stall=%0d: got %0d bytes required 6", stall, n_got);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({g_pd[i], g_pu[i], g_code[i]} !== exp[i]) begin
        errors++;
        $display("FAIL upper_a_byte%0d stall=%0d: got %h required %h",
                 i, stall, {g_pd[i], g_pu[i], g_code[i]}, exp[i]);
      end
    end
    if (!stall) begin
      checks++;
      if (g_cyc[5] !== 1 + 5 * STEP || ready_cyc !== 1 + 6 * STEP) begin
        errors++;
        $display("FAIL upper_a_timing: got last=%0d ready=%0d required %0d %0d",
                 g_cyc[5], ready_cyc, 1 + 5 * STEP, 1 + 6 * STEP);
      end
    end
  endtask

  task automatic test_unmapped();
    logic lang_before;
    lang_before = lang_state;
    send_char(8'h80, ~lang_state);
    @(negedge clk);
    checks++;
    if (err_unmapped !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL unmapped_pulse: got err=%b v=%b in_ready=%b required 1 0 0",
               err_unmapped, out_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (err_unmapped !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || lang_state !== lang_before) begin
      errors++;
      $display("FAIL unmapped_after: got err=%b v=%b in_ready=%b lang=%b required 0 0 1 %b",
               err_unmapped, out_valid, in_ready, lang_state, lang_before);
    end
  endtask

  task automatic test_lang();
    logic [9:0] exp  [9];
    logic [9:0] exp2 [3];
    exp  = '{{2'b10, 8'h0E}, {2'b00, 8'hF0}, {2'b01, 8'h0E}, {2'b10, 8'h12}, {2'b10, 8'h16},
             {2'b00, 8'hF0}, {2'b01, 8'h16}, {2'b00, 8'hF0}, {2'b01, 8'h12}};
    exp2 = '{{2'b10, 8'h1C}, {2'b00, 8'hF0}, {2'b01, 8'h1C}};
    test_reset();
    send_char("!", 1'b1);
    collect(1'b0);
    checks++;
    if (n_got !== 9) begin
      errors++;
      $display("FAIL lang_count: got %0d bytes required 9", n_got);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if ({g_pd[i], g_pu[i], g_code[i]} !== exp[i]) begin
        errors++;
        $display("FAIL lang_byte%0d: got %h required %h", i, {g_pd[i], g_pu[i], g_code[i]}, exp[i]);
      end
    end
    checks++;
    if (g_lang[2] !== 1'b0 || g_lang[3] !== 1'b1 || lang_state !== 1'b1) begin
      errors++;
      $display("FAIL lang_toggle: got at byte2=%b byte3=%b end=%b required 0 1 1",
               g_lang[2], g_lang[3], lang_state);
    end
    send_char("a", 1'b1);
    collect(1'b0);
    checks++;
    if (n_got !== 3) begin
      errors++;
      $display("FAIL lang_repeat_count: got %0d bytes required 3", n_got);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({g_pd[i], g_pu[i], g_code[i]} !== exp2[i]) begin
        errors++;
        $display("FAIL lang_repeat_byte%0d: got %h required %h", i, {g_pd[i], g_pu[i], g_code[i]}, exp2[i]);
      end
    end
  endtask

  task automatic test_map_table();
    logic [7:0] chars  [9];
    logic [7:0] codes  [9];
    logic       shifts [9];
    logic [9:0] exp    [6];
    int         nexp;
    chars  = '{8'h0D, 8'h0A, 8'h08, 8'h20, 8'h2C, 8'h3F, 8'h7A, 8'h30, 8'h29};
    codes  = '{8'h5A, 8'h5A, 8'h66, 8'h29, 8'h41, 8'h4A, 8'h1A, 8'h45, 8'h45};
    shifts = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int t = 0; t < 9; t++) begin
      if (shifts[t]) begin
        exp  = '{{2'b10, 8'h12}, {2'b10, codes[t]}, {2'b00, 8'hF0},
                 {2'b01, codes[t]}, {2'b00, 8'hF0}, {2'b01, 8'h12}};
        nexp = 6;
      end else begin
        exp  = '{{2'b10, codes[t]}, {2'b00, 8'hF0}, {2'b01, codes[t]}, 10'h0, 10'h0, 10'h0};
        nexp = 3;
      end
      send_char(chars[t], lang_state);
      collect(1'b0);
      checks++;
      if (n_got !== nexp) begin
        errors++;
        $display("FAIL map_%h_count: got %0d bytes required %0d", chars[t], n_got, nexp);
      end
      for (int i = 0; i < nexp; i++) begin
        checks++;
        if ({g_pd[i], g_pu[i], g_code[i]} !== exp[i]) begin
          errors++;
          $display("FAIL map_%h_byte%0d: got %h required %h", chars[t], i, {g_pd[i], g_pu[i], g_code[i]}, exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int hs;
    logic [9:0] exp [3];
    exp = '{{2'b10, 8'h1C}, {2'b00, 8'hF0}, {2'b01, 8'h1C}};
    send_char("A", lang_state);
    hs = 0;
    for (int k = 0; k < 100 && hs < 2; k++) begin
      @(negedge clk);
      if (out_valid) hs++;
    end
    checks++;
    if (hs !== 2) begin
      errors++;
      $display("FAIL reset_mid_bytes: got %0d bytes before timeout required 2", hs);
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_code, out_push_down, out_push_up, lang_state, busy, in_ready} !== 15'h1) begin
      errors++;
      $display("FAIL reset_mid_outputs: got v=%b code=%h pd=%b pu=%b lang=%b busy=%b in_ready=%b required 0 00 0 0 0 0 1",
               out_valid, out_code, out_push_down, out_push_up, lang_state, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_char("a", 1'b0);
    collect(1'b0);
    checks++;
    if (n_got !== 3) begin
      errors++;
      $display("FAIL reset_mid_after_count: got %0d bytes required 3", n_got);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({g_pd[i], g_pu[i], g_code[i]} !== exp[i]) begin
        errors++;
        $display("FAIL reset_mid_after_byte%0d: got %h required %h", i, {g_pd[i], g_pu[i], g_code[i]}, exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lower_a();
    test_upper_a(1'b0, 1'b0);
    test_unmapped();
    test_lang();
    test_unmapped();
    test_map_table();
    test_upper_a(1'b1, lang_state);
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascii_to_scancode.md
Name: ascii_to_scancode

Overview:
- Transmit-side counterpart of the keyboard decode path. Accepts one ASCII character per handshake and emits the PS/2 Set-2 make/break byte sequence a keyboard would send to type it.
- Wraps shifted characters in Shift make/break. Inserts a language-toggle keystroke (0x0E) when the requested language differs from the tracked language state.
- Sits between a character source (test text ROM, UART bridge) and a PS/2 device-side serializer or loopback into the decode path.

Parameters:
- GAP_CYCLES, 16, idle cycles forced between output bytes; used only when ASCII_TO_SCANCODE_GAP_EN is defined.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_ascii  in  8  character to type
- in_lang  in  1  requested language state for this character (0/1)
- in_valid  in  1  in_ascii/in_lang valid
- in_ready  out  1  high only in IDLE; character accepted on in_valid & in_ready
- out_code  out  8  scancode byte
- out_valid  out  1  out_code valid
- out_ready  in  1  downstream accepts byte on out_valid & out_ready
- out_push_down  out  1  high with out_valid when out_code is a make byte
- out_push_up  out  1  high with out_valid when out_code is the key byte following 0xF0
- lang_state  out  1  tracked language state
- busy  out  1  high in any non-IDLE state
- err_unmapped  out  1  one-cycle pulse when an accepted character has no mapping

Behaviour:
- Reset (async, rst_n low): state IDLE; in_ready=1 once rst_n is released; out_valid=0; out_code=0x00; out_push_down=0; out_push_up=0; lang_state=0; busy=0; err_unmapped=0. Reset mid-sequence aborts immediately with no trailing break bytes.
- Lookup: the combinational LUT returns {mapped, shift, code}.
  - 'a'-'z' → code, shift=0; 'A'-'Z' → same code, shift=1 (e.g. a/A=0x1C).
  - '1'=0x16, '!'=0x16+shift; space=0x29; 0x0A and 0x0D=0x5A; 0x08=0x66.
  - Punctuation follows US layout. All other values are unmapped.
- Accept cycle N: capture the character, compute lang_mismatch = in_lang != lang_state, and leave IDLE. The first byte is valid at N+1 with registered outputs.
- FSM states, in order, each skipped if not needed: LANG_MK(0x0E, push_down), LANG_F0(0xF0), LANG_BRK(0x0E, push_up), SHIFT_MK(0x12, push_down), KEY_MK(code, push_down), KEY_F0(0xF0), KEY_BRK(code, push_up), SHIFT_F0(0xF0), SHIFT_BRK(0x12, push_up), then IDLE.
  - LANG_* states run only on mismatch. SHIFT_* states run only when shift=1.
- Advance on out_valid & out_ready only. out_code and the push flags are held stable while out_valid & !out_ready.
- lang_state toggles in the cycle LANG_BRK completes its handshake.
- Unmapped character: no bytes emitted; err_unmapped pulses at N+1; lang_state unchanged; return to IDLE (in_ready=1 at N+2).
- Without gap: back-to-back bytes; out_valid stays high across a sequence when out_ready stays high. in_ready rises the cycle after the final handshake.
- 0xF0 bytes carry push_down=0 and push_up=0.

Optional Feature:
- ASCII_TO_SCANCODE_GAP_EN defined: after every byte handshake, out_valid is held 0 for GAP_CYCLES cycles via an internal counter, then the next byte is presented. Also applies before returning to IDLE.
- Undefined: no counter is built and there is no gap.

Decomposition:
- Shared package: scancode constants (SC_BREAK=0xF0, SC_LSHIFT=0x12, SC_RSHIFT=0x59, SC_CAPS=0x58, SC_LANG=0x0E, SC_ENTER=0x5A, SC_BKSP=0x66) and the FSM state enum. These are shared with the decode path.
- One sub-module: ascii_scancode_lut (purely combinational case table).

Test Plan:
- 'a', lang 0, out_ready=1 → 0x1C(pd), 0xF0, 0x1C(pu); 3 bytes in 3 consecutive cycles; in_ready back the cycle after.
- 'A' → 0x12(pd), 0x1C(pd), 0xF0, 0x1C(pu), 0xF0, 0x12(pu).
- '!' with in_lang=1 from reset → 0x0E, 0xF0, 0x0E, 0x12, 0x16, 0xF0, 0x16, 0xF0, 0x12. lang_state=1 after the 3rd byte. A second char with in_lang=1 emits no 0x0E.
- 0x80 → no out_valid, err_unmapped pulses one cycle, lang_state unchanged.
- 'A' with out_ready toggling randomly → identical byte order and no dropped or duplicated bytes; out_code stable while stalled.
- rst_n asserted after the 2nd byte of 'A' → outputs at reset values immediately; next 'a' yields a clean 3-byte sequence. With GAP_EN and GAP_CYCLES=4, 'a' → exactly 4 idle cycles between bytes.
